// File: rtl/scr1_accel_mac.sv
// Memory-mapped dot-product / MAC accelerator on the SCR1 dmem interface.
// Optional saturating accumulation: define SCR1_ACCEL_MAC_SAT_EN.

package scr1_accel_mac_pkg;

  localparam int unsigned SCR1_DMEM_AWIDTH = 32;
  localparam int unsigned SCR1_DMEM_DWIDTH = 32;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

endpackage

module scr1_accel_mac
  import scr1_accel_mac_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ELEM_W = 8,
  parameter int unsigned ACC_W  = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          dmem_req_ack,
  input  logic                          dmem_req,
  input  type_scr1_mem_cmd_e            dmem_cmd,
  input  type_scr1_mem_width_e          dmem_width,
  input  logic [SCR1_DMEM_AWIDTH-1:0]   dmem_addr,
  input  logic [SCR1_DMEM_DWIDTH-1:0]   dmem_wdata,
  output logic [SCR1_DMEM_DWIDTH-1:0]   dmem_rdata,
  output type_scr1_mem_resp_e           dmem_resp,
  output logic                          irq
);

  localparam int unsigned LANES = 32 / ELEM_W;
  localparam int unsigned IW    = $clog2(DEPTH);
  localparam int unsigned PW    = 2 * ELEM_W;
`ifdef SCR1_ACCEL_MAC_SAT_EN
  localparam int unsigned SUM_W = ACC_W + 8;
`else
  localparam int unsigned SUM_W = ACC_W;
`endif
  localparam logic [8:0] DEPTH_L = 9'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;

  state_e                 state_q, state_d;
  logic                   keep_q, sgn_q, irq_en_q, irq_en_d, done_q, done_d, ovf_q;
  logic [8:0]             len_q;
  logic [ACC_W-1:0]       acc_q, acc_nxt_c;
  logic [31:0]            cycles_q;
  logic [IW-1:0]          idx_q;
  logic [LANES-1:0][PW-1:0] prod_q, prod_c;
  logic                   prod_vld_q;
  logic [31:0]            mem_a [DEPTH];
  logic [31:0]            mem_b [DEPTH];
  logic [SUM_W-1:0]       sum_c;
  logic [63:0]            acc64_c;
  type_scr1_mem_resp_e    resp_q;
  logic [31:0]            rdata_q;
  logic                   irq_q;

  logic [11:0]            a12;
  logic                   wr_c, rd_c, busy_c, go_c, mode_we_c;
  logic                   sel_ctrl, sel_len, sel_lo, sel_hi, sel_cyc, sel_a, sel_b;
  logic [IW-1:0]          buf_idx;
  logic [31:0]            rd_word_c, merged_c, ctrl_rd_c;
  logic [8:0]             efflen_c;
  logic                   addr_unused;

  assign addr_unused  = ^dmem_addr[SCR1_DMEM_AWIDTH-1:12];
  assign dmem_req_ack = 1'b1;
  assign dmem_resp    = resp_q;
  assign dmem_rdata   = rdata_q;
  assign irq          = irq_q;

  // Address decode
  assign a12      = dmem_addr[11:0];
  assign wr_c     = dmem_req && (dmem_cmd == SCR1_MEM_CMD_WR);
  assign rd_c     = dmem_req && (dmem_cmd == SCR1_MEM_CMD_RD);
  assign sel_ctrl = (a12 == 12'h000);
  assign sel_len  = (a12 == 12'h004);
  assign sel_lo   = (a12 == 12'h008);
  assign sel_hi   = (a12 == 12'h00C);
  assign sel_cyc  = (a12 == 12'h010);
  assign sel_a    = (a12[11:8] == 4'h1);
  assign sel_b    = (a12[11:8] == 4'h2);
  assign buf_idx  = IW'(a12[7:2]);

  assign busy_c   = (state_q != ST_IDLE);
  assign efflen_c = (len_q > DEPTH_L) ? DEPTH_L : len_q;
  assign acc64_c  = sgn_q ? 64'($signed(acc_q)) : 64'(acc_q);
  assign ctrl_rd_c = {done_q, busy_c, ovf_q, 25'd0, irq_en_q, sgn_q, keep_q, 1'b0};

  // Sub-word writes only replace the addressed byte/halfword of the current word
  function automatic logic [31:0] merge_wr(input logic [31:0] old, input logic [31:0] wd,
                                           input type_scr1_mem_width_e w, input logic [1:0] off);
    logic [31:0] r;
    r = old;
    case (w)
      SCR1_MEM_WIDTH_BYTE:  r[{off, 3'b000} +: 8]        = wd[7:0];
      SCR1_MEM_WIDTH_HWORD: r[{off[1], 4'b0000} +: 16]   = wd[15:0];
      default:              r                            = wd;
    endcase
    return r;
  endfunction

  always_comb begin
    rd_word_c = '0;
    if (sel_ctrl)     rd_word_c = ctrl_rd_c;
    else if (sel_len) rd_word_c = 32'(len_q);
    else if (sel_lo)  rd_word_c = acc64_c[31:0];
    else if (sel_hi)  rd_word_c = acc64_c[63:32];
    else if (sel_cyc) rd_word_c = cycles_q;
    else if (sel_a)   rd_word_c = mem_a[buf_idx];
    else if (sel_b)   rd_word_c = mem_b[buf_idx];
  end

  assign merged_c  = merge_wr(rd_word_c, dmem_wdata, dmem_width, a12[1:0]);
  assign mode_we_c = wr_c && sel_ctrl && !busy_c;
  assign go_c      = mode_we_c && merged_c[0];

  // Next-state and sticky control bits
  always_comb begin
    state_d  = state_q;
    done_d   = done_q;
    irq_en_d = irq_en_q;
    if (mode_we_c) irq_en_d = merged_c[3];
    case (state_q)
      ST_IDLE: begin
        if (go_c) begin
          done_d  = 1'b0;
          state_d = (efflen_c == 9'd0) ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (9'(idx_q) == efflen_c - 9'd1) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Lane multipliers; low PW bits are exact for both signed and unsigned operands
  always_comb begin
    logic [PW-1:0] ax, bx;
    logic [31:0]   wa, wb;
    wa = mem_a[idx_q];
    wb = mem_b[idx_q];
    for (int unsigned k = 0; k < LANES; k++) begin
      ax = {{(PW-ELEM_W){sgn_q & wa[k*ELEM_W+ELEM_W-1]}}, wa[k*ELEM_W +: ELEM_W]};
      bx = {{(PW-ELEM_W){sgn_q & wb[k*ELEM_W+ELEM_W-1]}}, wb[k*ELEM_W +: ELEM_W]};
      prod_c[k] = ax * bx;
    end
  end

  always_comb begin
    sum_c = sgn_q ? SUM_W'($signed(acc_q)) : SUM_W'(acc_q);
    for (int unsigned k = 0; k < LANES; k++)
      sum_c = sum_c + (sgn_q ? SUM_W'($signed(prod_q[k])) : SUM_W'(prod_q[k]));
  end

`ifdef SCR1_ACCEL_MAC_SAT_EN
  localparam logic [ACC_W-1:0] S_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] S_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  logic sat_hit_c;

  always_comb begin
    sat_hit_c = 1'b0;
    acc_nxt_c = sum_c[ACC_W-1:0];
    if (sgn_q) begin
      if ((sum_c[SUM_W-1:ACC_W-1] != '0) && (sum_c[SUM_W-1:ACC_W-1] != '1)) begin
        sat_hit_c = 1'b1;
        acc_nxt_c = sum_c[SUM_W-1] ? S_MIN : S_MAX;
      end
    end else if (sum_c[SUM_W-1:ACC_W] != '0) begin
      sat_hit_c = 1'b1;
      acc_nxt_c = '1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      ovf_q <= 1'b0;
    else if (go_c && !merged_c[1]) ovf_q <= 1'b0;
    else if (prod_vld_q && sat_hit_c) ovf_q <= 1'b1;
  end
`else
  assign acc_nxt_c = sum_c;
  assign ovf_q     = 1'b0;
`endif

  // Register file, buffers and MAC pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keep_q     <= 1'b0;
      sgn_q      <= 1'b0;
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
      irq_q      <= 1'b0;
      len_q      <= '0;
      acc_q      <= '0;
      cycles_q   <= '0;
      idx_q      <= '0;
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      resp_q     <= SCR1_MEM_RESP_NOTRDY;
      rdata_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_a[i] <= '0;
        mem_b[i] <= '0;
      end
    end else begin
      done_q   <= done_d;
      irq_en_q <= irq_en_d;
      irq_q    <= done_d & irq_en_d;
      resp_q   <= dmem_req ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_NOTRDY;
      rdata_q  <= rd_c ? (rd_word_c >> {a12[1:0], 3'b000}) : '0;

      if (mode_we_c) begin
        keep_q <= merged_c[1];
        sgn_q  <= merged_c[2];
      end
      if (wr_c && sel_len && !busy_c) len_q <= merged_c[8:0];
      if (wr_c && sel_a && !busy_c) mem_a[buf_idx] <= merged_c;
      if (wr_c && sel_b && !busy_c) mem_b[buf_idx] <= merged_c;

      if (go_c) begin
        idx_q      <= '0;
        cycles_q   <= '0;
        prod_vld_q <= 1'b0;
        if (!merged_c[1]) acc_q <= '0;
      end else begin
        if (busy_c) cycles_q <= cycles_q + 32'd1;
        prod_vld_q <= (state_q == ST_RUN);
        if (state_q == ST_RUN) begin
          idx_q  <= idx_q + IW'(1);
          prod_q <= prod_c;
        end
        if (prod_vld_q) acc_q <= acc_nxt_c;
      end
    end
  end

endmodule

// File: tb/tb_scr1_accel_mac.sv
// Directed self-checking bench for scr1_accel_mac (default build: DEPTH=16, ELEM_W=8, ACC_W=32).

module tb_scr1_accel_mac;
  import scr1_accel_mac_pkg::*;

  localparam logic [31:0] A_CTRL = 32'h000;
  localparam logic [31:0] A_LEN  = 32'h004;
  localparam logic [31:0] A_LO   = 32'h008;
  localparam logic [31:0] A_HI   = 32'h00C;
  localparam logic [31:0] A_CYC  = 32'h010;
  localparam logic [31:0] A_A    = 32'h100;
  localparam logic [31:0] A_B    = 32'h200;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 req = 1'b0;
  type_scr1_mem_cmd_e   cmd = SCR1_MEM_CMD_RD;
  type_scr1_mem_width_e width = SCR1_MEM_WIDTH_WORD;
  logic [31:0]          addr = '0;
  logic [31:0]          wdata = '0;
  logic                 req_ack;
  logic [31:0]          rdata;
  type_scr1_mem_resp_e  resp;
  logic                 irq;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  scr1_accel_mac #(.DEPTH(16), .ELEM_W(8), .ACC_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .dmem_req_ack (req_ack),
    .dmem_req     (req),
    .dmem_cmd     (cmd),
    .dmem_width   (width),
    .dmem_addr    (addr),
    .dmem_wdata   (wdata),
    .dmem_rdata   (rdata),
    .dmem_resp    (resp),
    .irq          (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input type_scr1_mem_width_e w);
    req = 1'b1; cmd = SCR1_MEM_CMD_WR; addr = a; wdata = d; width = w;
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input type_scr1_mem_width_e w, output logic [31:0] d);
    req = 1'b1; cmd = SCR1_MEM_CMD_RD; addr = a; width = w;
    @(posedge clk); #1;
    d = rdata;
    req = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, SCR1_MEM_WIDTH_WORD, d);
    check(tag, d, exp);
  endtask

  task automatic wait_irq(output int n);
    n = 0;
    while (irq !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Returns cycles from the GO request cycle to the first cycle DONE (and irq) is visible
  task automatic run_go(input logic [31:0] ctrl, output int lat);
    int n;
    wr(A_CTRL, ctrl, SCR1_MEM_WIDTH_WORD);
    wait_irq(n);
    lat = n + 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          n;
    logic [31:0] d;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_resp",  32'(resp), 32'(SCR1_MEM_RESP_NOTRDY));
    check("rst_rdata", rdata, 32'h0);
    check("rst_irq",   32'(irq), 32'h0);
    check("req_ack",   32'(req_ack), 32'h1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_rd("rst_ctrl", A_CTRL, 32'h0);
    check("resp_rd", 32'(resp), 32'(SCR1_MEM_RESP_RDY_OK));
    chk_rd("rst_lo",  A_LO, 32'h0);
    chk_rd("rst_cyc", A_CYC, 32'h0);
    @(posedge clk); #1;
    check("resp_idle", 32'(resp), 32'(SCR1_MEM_RESP_NOTRDY));

    // Basic unsigned dot product, one word
    wr(A_A, 32'h04030201, SCR1_MEM_WIDTH_WORD);
    check("resp_wr", 32'(resp), 32'(SCR1_MEM_RESP_RDY_OK));
    wr(A_B, 32'h01010101, SCR1_MEM_WIDTH_WORD);
    wr(A_LEN, 32'd1, SCR1_MEM_WIDTH_WORD);
    run_go(32'h9, lat);
    check("lat1", 32'(lat), 32'd3);
    chk_rd("res1", A_LO, 32'd10);
    chk_rd("hi1", A_HI, 32'd0);
    chk_rd("cyc1", A_CYC, 32'd2);
    chk_rd("ctrl_done", A_CTRL, 32'h80000008);
    check("irq_hold", 32'(irq), 32'h1);

    // Signed vs unsigned, and wrap-around with ACC_KEEP
    wr(A_A, 32'h000000FF, SCR1_MEM_WIDTH_WORD);
    wr(A_B, 32'h00000002, SCR1_MEM_WIDTH_WORD);
    run_go(32'hD, lat);
    check("lat_s", 32'(lat), 32'd3);
    chk_rd("res_s", A_LO, 32'hFFFFFFFE);
    chk_rd("hi_s", A_HI, 32'hFFFFFFFF);
    run_go(32'hB, lat);
    chk_rd("res_wrap", A_LO, 32'h000001FC);
    chk_rd("hi_wrap", A_HI, 32'h0);
    run_go(32'h9, lat);
    chk_rd("res_u", A_LO, 32'h000001FE);

    // LEN=4 then ACC_KEEP, with writes issued while busy
    for (int i = 0; i < 4; i++) begin
      wr(A_A + 32'(4 * i), 32'h01010101, SCR1_MEM_WIDTH_WORD);
      wr(A_B + 32'(4 * i), 32'h01010101, SCR1_MEM_WIDTH_WORD);
    end
    wr(A_LEN, 32'd4, SCR1_MEM_WIDTH_WORD);
    run_go(32'h9, lat);
    check("lat4", 32'(lat), 32'd6);
    chk_rd("res4", A_LO, 32'd16);
    chk_rd("cyc4", A_CYC, 32'd5);
    wr(A_CTRL, 32'hB, SCR1_MEM_WIDTH_WORD);
    wr(A_CTRL, 32'h9, SCR1_MEM_WIDTH_WORD);
    wr(A_LEN, 32'd1, SCR1_MEM_WIDTH_WORD);
    chk_rd("ctrl_busy", A_CTRL, 32'h4000000A);
    wait_irq(n);
    check("lat_keep", 32'(n), 32'd2);
    chk_rd("res_keep", A_LO, 32'd32);
    chk_rd("cyc_keep", A_CYC, 32'd5);
    chk_rd("len_kept", A_LEN, 32'd4);

    // Zero length
    wr(A_LEN, 32'd0, SCR1_MEM_WIDTH_WORD);
    run_go(32'hB, lat);
    check("lat0", 32'(lat), 32'd2);
    chk_rd("res0", A_LO, 32'd32);
    chk_rd("cyc0", A_CYC, 32'd1);

    // LEN above DEPTH is clamped
    for (int i = 4; i < 16; i++) begin
      wr(A_A + 32'(4 * i), 32'h01010101, SCR1_MEM_WIDTH_WORD);
      wr(A_B + 32'(4 * i), 32'h01010101, SCR1_MEM_WIDTH_WORD);
    end
    wr(A_LEN, 32'd300, SCR1_MEM_WIDTH_WORD);
    chk_rd("len300", A_LEN, 32'd300);
    run_go(32'h9, lat);
    check("lat16", 32'(lat), 32'd18);
    chk_rd("res16", A_LO, 32'd64);
    chk_rd("cyc16", A_CYC, 32'd17);

    // Sub-word access, aliasing and unmapped space
    wr(A_A, 32'h0, SCR1_MEM_WIDTH_WORD);
    wr(32'h101, 32'h000000AB, SCR1_MEM_WIDTH_BYTE);
    chk_rd("byte_wr", A_A, 32'h0000AB00);
    rd(32'h101, SCR1_MEM_WIDTH_BYTE, d);
    check("byte_rd", d, 32'h000000AB);
    wr(32'h102, 32'h00001234, SCR1_MEM_WIDTH_HWORD);
    chk_rd("hw_wr", A_A, 32'h1234AB00);
    rd(32'h102, SCR1_MEM_WIDTH_HWORD, d);
    check("hw_rd", d, 32'h00001234);
    wr(32'h140, 32'hCAFEF00D, SCR1_MEM_WIDTH_WORD);
    chk_rd("alias", A_A, 32'hCAFEF00D);
    wr(32'h014, 32'hFFFFFFFF, SCR1_MEM_WIDTH_WORD);
    chk_rd("unmap", 32'h014, 32'h0);
    check("unmap_resp", 32'(resp), 32'(SCR1_MEM_RESP_RDY_OK));
    chk_rd("unmap300", 32'h300, 32'h0);

    // Asynchronous reset in the middle of a run
    wr(A_LEN, 32'd16, SCR1_MEM_WIDTH_WORD);
    wr(A_CTRL, 32'h9, SCR1_MEM_WIDTH_WORD);
    rd(A_CTRL, SCR1_MEM_WIDTH_WORD, d);
    check("busy_mid", d, 32'h40000008);
    check("resp_mid", 32'(resp), 32'(SCR1_MEM_RESP_RDY_OK));
    rst = 1'b1;
    #1;
    check("arst_resp",  32'(resp), 32'(SCR1_MEM_RESP_NOTRDY));
    check("arst_rdata", rdata, 32'h0);
    #1;
    rst = 1'b0;
    chk_rd("arst_ctrl", A_CTRL, 32'h0);
    chk_rd("arst_lo",   A_LO, 32'h0);
    chk_rd("arst_len",  A_LEN, 32'h0);
    chk_rd("arst_a0",   A_A, 32'h0);
    repeat (20) @(posedge clk);
    #1;
    check("arst_nodone", 32'(irq), 32'h0);
    chk_rd("arst_ctrl2", A_CTRL, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/scr1_accel_mac.md
Name: scr1_accel_mac

Overview:
Memory-mapped dot-product/MAC accelerator on the SCR1 core data interface (dmem). Software fills two operand buffers of DEPTH words and sets LEN and mode. Writing GO makes the block stream LEN word pairs through LANES parallel multipliers into one accumulator. Completion is reported by a sticky DONE bit and a cycle counter.

Parameters:
DEPTH, 16, words per operand buffer (A and B); power of two, 2..256
ELEM_W, 8, element width in bits; 8 or 16; LANES = 32/ELEM_W
ACC_W, 32, accumulator width; 32..48; RESULT_LO = acc[31:0], RESULT_HI = sign/zero-extended acc[ACC_W-1:32]

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
dmem_req_ack  out  1  request accept; tied 1
dmem_req  in  1  request valid
dmem_cmd  in  type_scr1_mem_cmd_e  RD/WR
dmem_width  in  type_scr1_mem_width_e  BYTE/HWORD/WORD
dmem_addr  in  SCR1_DMEM_AWIDTH  byte address; bits [11:0] decoded
dmem_wdata  in  SCR1_DMEM_DWIDTH  write data
dmem_rdata  out  SCR1_DMEM_DWIDTH  read data, valid with dmem_resp
dmem_resp  out  type_scr1_mem_resp_e  response
irq  out  1  level high while DONE=1 and IRQ_EN=1

Behaviour:
- Reset (async, rst=1): FSM IDLE; CTRL, LEN, RESULT, CYCLES, index, product regs, both buffers = 0; dmem_resp=NOTRDY; dmem_rdata=0; irq=0.
- Handshake: every request accepted. dmem_resp=RDY_OK exactly one cycle after a cycle with dmem_req=1, otherwise NOTRDY. Read data is registered from the request cycle and shifted right by 8*addr[1:0].
- Writes: BYTE/HWORD writes update only the addressed byte/halfword (data taken from wdata[7:0]/[15:0]). Unmapped addresses: read 0, write ignored, response RDY_OK.
- Map (offset):
  - 0x000 CTRL: bit0 GO (write-1 pulse, reads 0); bit1 ACC_KEEP; bit2 SIGNED; bit3 IRQ_EN; bit29 OVF (SAT build only); bit30 BUSY (RO); bit31 DONE (RO, sticky).
  - 0x004 LEN, bits [8:0].
  - 0x008 RESULT_LO, RO.
  - 0x00C RESULT_HI, RO.
  - 0x010 CYCLES, RO: cycles from GO to DONE.
  - 0x100+4i A[i]; 0x200+4i B[i]; i<DEPTH; higher indices alias modulo DEPTH.
- FSM:
  - IDLE -> RUN on GO write. That cycle: DONE cleared; index=0; CYCLES=0; acc cleared unless ACC_KEEP=1.
  - Effective length = min(LEN, DEPTH). If effective length=0, go IDLE -> DRAIN directly.
  - RUN: each cycle, products of A[index]/B[index] lanes are registered (lane k = bits [k*ELEM_W +: ELEM_W]; SIGNED selects two's-complement); index++. After index = efflen-1, -> DRAIN.
  - DRAIN: one cycle to add the last registered products into acc; -> IDLE, DONE=1.
  - Product stage adds lane-sum into acc each cycle after the first RUN cycle.
  - Latency GO-write to DONE visible = efflen+2 cycles; CYCLES = efflen+1.
- BUSY=1 in RUN and DRAIN. While BUSY: GO ignored; writes to CTRL mode bits, LEN, A, B dropped; reads return live values.
- Arithmetic: lane products are 2*ELEM_W bits, extended to ACC_W before summing. Default build: acc wraps mod 2^ACC_W.
- Simultaneous GO and buffer write in the same request are impossible (single port). DONE stays 1 until the next accepted GO.
- Reset mid-RUN: immediate abort to reset state; no DONE.

Optional Feature:
SCR1_ACCEL_MAC_SAT_EN
- Defined: each accumulate saturates to ACC_W-bit max/min (signed when SIGNED=1, else unsigned max) and sets sticky CTRL.OVF. OVF is cleared by GO with ACC_KEEP=0.
- Undefined: wrap-around accumulation; bit29 reads 0.

Test Plan:
- A[0]=0x04030201, B[0]=0x01010101, LEN=1, GO -> DONE after 3 cycles, RESULT_LO=10, CYCLES=2.
- SIGNED=1, A[0]=0x000000FF, B[0]=0x00000002, LEN=1 -> RESULT_LO=0xFFFFFFFE; same with SIGNED=0 -> 0x1FE.
- LEN=4, all A/B words 0x01010101, run twice with ACC_KEEP=1 on the second run -> RESULT_LO=16 then 32; GO written while BUSY has no effect.
- LEN=0 -> DONE after 2 cycles, RESULT unchanged with ACC_KEEP=1. LEN=300 with DEPTH=16 -> 16 words processed, CYCLES=17.
- SAT build, ACC_W=32, SIGNED=0, 16 words 0xFFFFFFFF x 0xFFFFFFFF repeated with ACC_KEEP -> RESULT_LO saturates at 0xFFFFFFFF, OVF=1. Non-SAT build -> wrapped value.
- Byte write 0xAB to 0x101 -> A[0]=0x0000AB00; byte read at 0x101 -> rdata=0x000000AB. Assert rst mid-RUN -> BUSY=0, DONE=0, RESULT=0, resp NOTRDY.
